module_operand_capture: RTL and testbench

//  Keypad-to-operand front end. Accumulates decimal key digits into binary

---
 rtl/module_operand_capture.sv | 150 +++++++++++++++
 tb/tb_module_operand_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/module_operand_capture.sv
// Keypad-to-operand front end: accumulates decimal digits into binary operands and
// commits them on the shared num bus with one-cycle load_a / load_b strobes.
// Optional build macro OPERAND_SAT_EN: an overflowing digit saturates the operand
// instead of being rejected.
module module_operand_capture #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] num,
  output logic             load_a,
  output logic             load_b,
  output logic             done,
  output logic             err,
  output logic [1:0]       digits
);

  localparam int unsigned SumW = WIDTH + 4;

  localparam logic [3:0] KeyA     = 4'hA;
  localparam logic [3:0] KeyB     = 4'hB;
  localparam logic [3:0] KeyClear = 4'hC;

  localparam logic [SumW-1:0] AccMax = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [1:0]      MaxDig = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {StA, StB, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [1:0]       digits_q, digits_d;
  logic             load_a_q, load_a_d;
  logic             load_b_q, load_b_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic            is_digit;
  logic            digit_full;
  logic            overflow;
  logic [SumW-1:0] sum;

  // Digit append is computed wide enough that acc*10+9 never wraps.
  assign is_digit   = (key_code <= 4'd9);
  assign digit_full = (digits_q >= MaxDig);
  assign sum        = {4'b0000, acc_q} * SumW'(10) + SumW'(key_code);
  assign overflow   = (sum > AccMax);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StA;
      acc_q    <= '0;
      num_q    <= '0;
      digits_q <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      digits_q <= digits_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state: commits advance the operand phase, clear always returns to A.
  always_comb begin
    state_d = state_q;
    if (key_valid) begin
      if (key_code == KeyClear) begin
        state_d = StA;
      end else if (key_code == KeyA && state_q == StA) begin
        state_d = StB;
      end else if (key_code == KeyB && state_q == StB) begin
        state_d = StDone;
      end
    end
  end

  // Datapath next values and one-cycle strobes for the accepted or rejected key.
  always_comb begin
    acc_d    = acc_q;
    digits_d = digits_q;
    num_d    = num_q;
    load_a_d = 1'b0;
    load_b_d = 1'b0;
    done_d   = done_q;
    err_d    = 1'b0;
    if (key_valid) begin
      if (is_digit) begin
        if (state_q == StDone || digit_full) begin
          err_d = 1'b1;
        end else if (overflow) begin
          err_d = 1'b1;
`ifdef OPERAND_SAT_EN
          acc_d    = '1;
          digits_d = digits_q + 2'd1;
`endif
        end else begin
          acc_d    = sum[WIDTH-1:0];
          digits_d = digits_q + 2'd1;
        end
      end else if (key_code == KeyA) begin
        if (state_q == StA) begin
          num_d    = acc_q;
          load_a_d = 1'b1;
          acc_d    = '0;
          digits_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end else if (key_code == KeyB) begin
        if (state_q == StB) begin
          num_d    = acc_q;
          load_b_d = 1'b1;
          acc_d    = '0;
          digits_d = '0;
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (key_code == KeyClear) begin
        acc_d    = '0;
        digits_d = '0;
        done_d   = 1'b0;
      end
      // 0xD-0xF fall through untouched and raise no error.
    end
  end

  // Outputs come straight from registers so they are glitch-free downstream.
  always_comb begin
    num    = num_q;
    load_a = load_a_q;
    load_b = load_b_q;
    done   = done_q;
    err    = err_q;
    digits = digits_q;
  end

endmodule

// File: tb/tb_module_operand_capture.sv
// Bench for module_operand_capture: a phase/accumulator model checked every cycle,
// plus literal expectations at the interesting points of each directed sequence.
module tb_module_operand_capture;

  localparam int W    = 8;
  localparam int MAXD = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] num;
  logic         load_a;
  logic         load_b;
  logic         done;
  logic         err;
  logic [1:0]   digits;

  int checks   = 0;
  int failures = 0;

  module_operand_capture #(
    .WIDTH(W),
    .MAX_DIGITS(MAXD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .num      (num),
    .load_a   (load_a),
    .load_b   (load_b),
    .done     (done),
    .err      (err),
    .digits   (digits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = entering A, 1 = entering B, 2 = both committed.
  int m_phase = 0;
  int m_acc   = 0;
  int m_dig   = 0;
  int m_num   = 0;
  bit m_la    = 1'b0;
  bit m_lb    = 1'b0;
  bit m_err   = 1'b0;
  bit m_done  = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int s;
    m_la  <= 1'b0;
    m_lb  <= 1'b0;
    m_err <= 1'b0;
    if (rst) begin
      m_phase <= 0;
      m_acc   <= 0;
      m_dig   <= 0;
      m_num   <= 0;
      m_done  <= 1'b0;
      m_valid <= 1'b1;
    end else if (key_valid) begin
      if (key_code <= 4'd9) begin
        s = m_acc * 10 + int'(key_code);
        if (m_phase == 2 || m_dig == MAXD) begin
          m_err <= 1'b1;
        end else if (s > MAXV) begin
          m_err <= 1'b1;
`ifdef OPERAND_SAT_EN
          m_acc <= MAXV;
          m_dig <= m_dig + 1;
`endif
        end else begin
          m_acc <= s;
          m_dig <= m_dig + 1;
        end
      end else if (key_code == 4'hA) begin
        if (m_phase == 0) begin
          m_num <= m_acc; m_la <= 1'b1; m_acc <= 0; m_dig <= 0; m_phase <= 1;
        end else begin
          m_err <= 1'b1;
        end
      end else if (key_code == 4'hB) begin
        if (m_phase == 1) begin
          m_num <= m_acc; m_lb <= 1'b1; m_acc <= 0; m_dig <= 0; m_phase <= 2;
          m_done <= 1'b1;
        end else begin
          m_err <= 1'b1;
        end
      end else if (key_code == 4'hC) begin
        m_acc <= 0; m_dig <= 0; m_done <= 1'b0; m_phase <= 0;
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_num", 32'(num), 32'(m_num));
      chk("cyc_load_a", 32'(load_a), 32'(m_la));
      chk("cyc_load_b", 32'(load_b), 32'(m_lb));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_err", 32'(err), 32'(m_err));
      chk("cyc_digits", 32'(digits), 32'(m_dig));
      chk("cyc_no_overlap", 32'(load_a & load_b), 32'd0);
    end
  end

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_load_a", 32'(load_a), 32'd0);
    chk("rst_load_b", 32'(load_b), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    rst = 1'b0;

    // 123 into A, 45 into B.
    press(4'h1); press(4'h2); press(4'h3);
    chk("a123_digits", 32'(digits), 32'd3);
    press(4'hA);
    chk("a123_load_a", 32'(load_a), 32'd1);
    chk("a123_num", 32'(num), 32'd123);
    press(4'h4); press(4'h5); press(4'hB);
    chk("b45_load_b", 32'(load_b), 32'd1);
    chk("b45_num", 32'(num), 32'd45);
    chk("b45_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("b45_strobe_1cyc", 32'(load_b), 32'd0);
    chk("b45_done_level", 32'(done), 32'd1);

    // Extra keys while done: digit and A rejected, 0xE silent.
    press(4'h7);
    chk("done_digit_err", 32'(err), 32'd1);
    press(4'hE);
    chk("ignore_e_noerr", 32'(err), 32'd0);
    press(4'hA);
    chk("done_a_err", 32'(err), 32'd1);
    chk("done_a_noload", 32'(load_a), 32'd0);

    // 9,9,9 overflows on the third digit.
    press(4'hC);
    chk("clear_done", 32'(done), 32'd0);
    press(4'h9); press(4'h9);
    chk("ovf_pre_err", 32'(err), 32'd0);
    press(4'h9);
    chk("ovf_err", 32'(err), 32'd1);
`ifdef OPERAND_SAT_EN
    chk("ovf_digits", 32'(digits), 32'd3);
    press(4'hA);
    chk("ovf_num", 32'(num), 32'd255);
`else
    chk("ovf_digits", 32'(digits), 32'd2);
    press(4'hA);
    chk("ovf_num", 32'(num), 32'd99);
`endif

    // Fourth digit rejected.
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("d4_err", 32'(err), 32'd1);
    chk("d4_digits", 32'(digits), 32'd3);
    press(4'hA);
    chk("d4_num", 32'(num), 32'd123);

    // Clear discards a partial operand; empty commit is 0.
    press(4'hC);
    press(4'h7); press(4'hC); press(4'hA);
    chk("clr_load_a", 32'(load_a), 32'd1);
    chk("clr_num", 32'(num), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    press(4'hC);
    press(4'hB);
    chk("b_in_a_err", 32'(err), 32'd1);
    chk("b_in_a_noload", 32'(load_b), 32'd0);

    // Reset mid-entry discards the partial digit.
    press(4'h5);
    pulse_rst();
    chk("midrst_digits", 32'(digits), 32'd0);
    press(4'hA);
    chk("midrst_load_a", 32'(load_a), 32'd1);
    chk("midrst_num", 32'(num), 32'd0);

    // A then B on consecutive cycles.
    press(4'hC);
    press(4'h4); press(4'h2);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'hA;
    @(negedge clk);
    key_code  = 4'hB;
    chk("b2b_load_a", 32'(load_a), 32'd1);
    chk("b2b_load_a_only", 32'(load_b), 32'd0);
    chk("b2b_num_a", 32'(num), 32'd42);
    @(negedge clk);
    key_valid = 1'b0;
    chk("b2b_load_b", 32'(load_b), 32'd1);
    chk("b2b_load_b_only", 32'(load_a), 32'd0);
    chk("b2b_num_b", 32'(num), 32'd0);
    chk("b2b_done", 32'(done), 32'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
